// File: rtl/uart_rx_ms.sv
// uart_rx_ms: parametrised oversampling UART receiver.
// The line is synchronised and each bit is decided by a 3-sample majority vote.
// Break and framing errors are detected, and received words sit in a valid/ready
// holding register that reports overruns.
// Build option: define UART_RX_PARITY_EN to expect and check one parity bit per
// frame. Without it, o_parity_err is always 0 and i_parity_odd is ignored.
module uart_rx_ms #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int STOP_BITS   = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_baud_tick,
    input  logic                 i_rx,
    input  logic                 i_parity_odd,
    input  logic                 i_ready,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_break,
    output logic                 o_overrun,
    output logic                 o_busy
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] SAMP_A   = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] SAMP_B   = CNT_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] SAMP_C   = CNT_W'(OVERSAMPLE / 2 + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
`ifdef UART_RX_PARITY_EN
        ST_PARITY    = 3'd3,
`endif
        ST_STOP      = 3'd4,
        ST_WAIT_IDLE = 3'd5
    } state_t;

    state_t                 state_reg, state_next;
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CNT_W-1:0]       tick_cnt_reg;
    logic [BIT_W-1:0]       bit_cnt_reg;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   samp_a_reg, samp_b_reg;
    logic                   all_zero_reg;   // every bit so far in this frame was 0
    logic                   frame_err_reg;  // an earlier stop bit of this frame was 0
    logic                   parity_err_reg;

    logic rx_sync, start_detect, in_frame, bit_eval, majority;
    logic frame_done, word_break, word_frame_err, word_parity_err;

    assign rx_sync      = sync_reg[SYNC_STAGES-1];
    assign start_detect = (state_reg == ST_IDLE) && i_baud_tick && !rx_sync;
    assign in_frame     = (state_reg != ST_IDLE) && (state_reg != ST_WAIT_IDLE);
    assign bit_eval     = in_frame && i_baud_tick && (tick_cnt_reg == SAMP_C);
    assign majority     = (samp_a_reg & samp_b_reg) | (samp_a_reg & rx_sync) |
                          (samp_b_reg & rx_sync);

`ifndef UART_RX_PARITY_EN
    logic unused_parity_odd;
    assign unused_parity_odd = i_parity_odd;
`endif

    // Input synchroniser: idles high so reset never looks like a start bit
    always_ff @(posedge i_clk) begin
        if (i_rst) sync_reg <= '1;
        else       sync_reg <= {sync_reg[SYNC_STAGES-2:0], i_rx};
    end

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state_reg <= ST_IDLE;
        else       state_reg <= state_next;
    end

    // Next-state logic; everything advances only on a baud tick
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:      if (start_detect) state_next = ST_START;
            ST_START:     if (bit_eval) state_next = majority ? ST_IDLE : ST_DATA;
            ST_DATA:      if (bit_eval && bit_cnt_reg == DATA_LAST)
`ifdef UART_RX_PARITY_EN
                              state_next = ST_PARITY;
            ST_PARITY:    if (bit_eval) state_next = ST_STOP;
`else
                              state_next = ST_STOP;
`endif
            ST_STOP:      if (bit_eval && bit_cnt_reg == STOP_LAST)
                              state_next = majority ? ST_IDLE : ST_WAIT_IDLE;
            ST_WAIT_IDLE: if (i_baud_tick && rx_sync) state_next = ST_IDLE;
            default:      state_next = ST_IDLE;
        endcase
    end

    // Output decode: end-of-frame strobe and the status of the finished word
    always_comb begin
        o_busy          = (state_reg != ST_IDLE);
        frame_done      = bit_eval && (state_reg == ST_STOP) && (bit_cnt_reg == STOP_LAST);
        word_frame_err  = frame_err_reg | ~majority;
        // Break looks at the first stop bit only; later stop bits just add framing errors
        word_break      = (bit_cnt_reg == '0) ? (all_zero_reg & ~majority) : all_zero_reg;
`ifdef UART_RX_PARITY_EN
        word_parity_err = parity_err_reg;
`else
        word_parity_err = 1'b0;
`endif
    end

    // Oversampling counters, sample capture and frame accumulation
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tick_cnt_reg   <= '0;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            samp_a_reg     <= 1'b1;
            samp_b_reg     <= 1'b1;
            all_zero_reg   <= 1'b0;
            frame_err_reg  <= 1'b0;
            parity_err_reg <= 1'b0;
        end else if (i_baud_tick) begin
            if (start_detect) begin
                tick_cnt_reg   <= '0;
                all_zero_reg   <= 1'b1;
                frame_err_reg  <= 1'b0;
                parity_err_reg <= 1'b0;
            end else if (tick_cnt_reg == CNT_LAST) begin
                tick_cnt_reg <= '0;
            end else begin
                tick_cnt_reg <= tick_cnt_reg + 1'b1;
            end
            if (in_frame && tick_cnt_reg == SAMP_A) samp_a_reg <= rx_sync;
            if (in_frame && tick_cnt_reg == SAMP_B) samp_b_reg <= rx_sync;
            if (bit_eval) begin
                // Bit counter restarts whenever the FSM moves to a new field
                if (state_next != state_reg) bit_cnt_reg <= '0;
                else                         bit_cnt_reg <= bit_cnt_reg + 1'b1;
                if (state_reg == ST_DATA) begin
                    shift_reg    <= {majority, shift_reg[DATA_BITS-1:1]};
                    all_zero_reg <= all_zero_reg & ~majority;
                end
`ifdef UART_RX_PARITY_EN
                if (state_reg == ST_PARITY) begin
                    parity_err_reg <= (majority != (^shift_reg ^ i_parity_odd));
                    all_zero_reg   <= all_zero_reg & ~majority;
                end
`endif
                if (state_reg == ST_STOP) begin
                    frame_err_reg <= word_frame_err;
                    if (bit_cnt_reg == '0) all_zero_reg <= all_zero_reg & ~majority;
                end
            end
        end
    end

    // Holding register: a full register only accepts a new word if it is being drained
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data       <= '0;
            o_valid      <= 1'b0;
            o_frame_err  <= 1'b0;
            o_parity_err <= 1'b0;
            o_break      <= 1'b0;
            o_overrun    <= 1'b0;
        end else begin
            o_overrun <= frame_done && o_valid && !i_ready;
            if (frame_done && (!o_valid || i_ready)) begin
                o_data       <= word_break ? '0 : shift_reg;
                o_valid      <= 1'b1;
                o_frame_err  <= word_frame_err;
                o_parity_err <= word_parity_err;
                o_break      <= word_break;
            end else if (o_valid && i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_ms.sv
// Testbench for uart_rx_ms: table-driven frames, hand-written corner cases and
// randomized frames checked against a frame-level reference model.
module tb_uart_rx_ms;
    localparam int OS = 16;
    localparam int SB = 1;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       baud_tick = 1'b0;
    logic       rx = 1'b1;
    logic       parity_odd = 1'b0;
    logic       ready = 1'b1;
    logic [7:0] data;
    logic       valid, fe, pe, brk, ovr, busy;

    int checks = 0;
    int errors = 0;
    int tick_div = 0;
    int ovr_cnt = 0;

    typedef struct packed {
        logic [7:0] d;
        logic       fe;
        logic       pe;
        logic       brk;
    } word_t;

    typedef struct {
        logic [7:0] d;
        logic       par_flip;
        logic       stop_bit;
        logic [7:0] exp_d;
        logic       exp_fe;
        logic       exp_pe;
        logic       exp_brk;
    } vec_t;

    word_t got_q[$];
    vec_t  vecs[7];

    uart_rx_ms #(.DATA_BITS(8), .OVERSAMPLE(OS), .STOP_BITS(SB), .SYNC_STAGES(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_baud_tick(baud_tick), .i_rx(rx),
        .i_parity_odd(parity_odd), .i_ready(ready), .o_data(data), .o_valid(valid),
        .o_frame_err(fe), .o_parity_err(pe), .o_break(brk), .o_overrun(ovr), .o_busy(busy)
    );

    always #5 clk = ~clk;

    // Baud tick every third clock
    always @(posedge clk) begin
        if (tick_div == 2) begin
            tick_div  <= 0;
            baud_tick <= 1'b1;
        end else begin
            tick_div  <= tick_div + 1;
            baud_tick <= 1'b0;
        end
    end

    // Monitor: record every word handed over and every overrun pulse
    always @(negedge clk) begin
        #1;
        if (!rst && valid && ready) got_q.push_back({data, fe, pe, brk});
        if (!rst && ovr) ovr_cnt++;
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_ticks(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            while (!baud_tick) @(negedge clk);
        end
    endtask

    task automatic drive(logic b, int n);
        rx = b;
        wait_ticks(n);
    endtask

    task automatic send_frame(logic [7:0] d, logic par, logic [1:0] stops);
        drive(1'b0, OS);
        for (int i = 0; i < 8; i++) drive(d[i], OS);
        if (PAR_EN) drive(par, OS);
        for (int s = 0; s < SB; s++) drive(stops[s], OS);
        rx = 1'b1;
    endtask

    // Frame-level reference: flags follow directly from the bits put on the line
    function automatic word_t model(logic [7:0] d, logic par, logic [1:0] stops, logic odd);
        word_t w;
        logic  b;
        w.fe = 1'b0;
        for (int s = 0; s < SB; s++) if (!stops[s]) w.fe = 1'b1;
        b = (d == 8'h00) && !stops[0];
        w.pe = 1'b0;
        if (PAR_EN) begin
            b    = b && !par;
            w.pe = (par != ((^d) ^ odd));
        end
        w.brk = b;
        w.d   = b ? 8'h00 : d;
        return w;
    endfunction

    task automatic expect_word(string name, word_t exp);
        word_t w;
        int    n = 0;
        while (got_q.size() == 0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        if (got_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: got no word expected data %02h", name, exp.d);
            return;
        end
        w = got_q.pop_front();
        check({name, " data"}, 32'(w.d), 32'(exp.d));
        check({name, " frame_err"}, 32'(w.fe), 32'(exp.fe));
        check({name, " parity_err"}, 32'(w.pe), 32'(exp.pe));
        check({name, " break"}, 32'(w.brk), 32'(exp.brk));
        $display("word %s: data=%02h fe=%0b pe=%0b brk=%0b", name, w.d, w.fe, w.pe, w.brk);
    endtask

    initial begin
        word_t     e;
        logic [7:0] d;
        logic       par, odd, flip;
        logic [1:0] stops;
        int         base;

        vecs[0] = '{8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{8'hA3, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1};
        vecs[6] = '{8'h81, 1'b1, 1'b1, 8'h81, 1'b0, PAR_EN, 1'b0};

        // Reset state
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset data", 32'(data), 32'h0);
        check("reset valid", 32'(valid), 32'h0);
        check("reset frame_err", 32'(fe), 32'h0);
        check("reset parity_err", 32'(pe), 32'h0);
        check("reset break", 32'(brk), 32'h0);
        check("reset overrun", 32'(ovr), 32'h0);
        check("reset busy", 32'(busy), 32'h0);
        drive(1'b1, OS);

        // Table-driven frames (even parity)
        for (int i = 0; i < 7; i++) begin
            d   = vecs[i].d;
            par = (^d) ^ vecs[i].par_flip;
            send_frame(d, par, {1'b1, vecs[i].stop_bit});
            drive(1'b1, OS);
            e.d = vecs[i].exp_d;  e.fe = vecs[i].exp_fe;
            e.pe = vecs[i].exp_pe; e.brk = vecs[i].exp_brk;
            expect_word($sformatf("vec%0d", i), e);
        end

        // Back-to-back 0x55, 0xA3
        send_frame(8'h55, ^8'h55, 2'b11);
        send_frame(8'hA3, ^8'hA3, 2'b11);
        drive(1'b1, OS);
        e = '{8'h55, 1'b0, 1'b0, 1'b0};
        expect_word("b2b first", e);
        e = '{8'hA3, 1'b0, 1'b0, 1'b0};
        expect_word("b2b second", e);

        // 4-tick low glitch: a false start, no word
        base = got_q.size();
        drive(1'b0, 4);
        check("glitch busy high", 32'(busy), 32'h1);
        drive(1'b1, 9);
        check("glitch busy cleared", 32'(busy), 32'h0);
        drive(1'b1, 2 * OS);
        check("glitch no word", 32'(got_q.size()), 32'(base));

        // 0x00 with a 1-tick high glitch on the centre sample of data bit 3
        drive(1'b0, OS);
        for (int i = 0; i < 3; i++) drive(1'b0, OS);
        drive(1'b0, 9);
        drive(1'b1, 1);
        drive(1'b0, 6);
        for (int i = 4; i < 8; i++) drive(1'b0, OS);
        if (PAR_EN) drive(1'b0, OS);
        drive(1'b1, 2 * OS);
        e = '{8'h00, 1'b0, 1'b0, 1'b0};
        expect_word("midbit glitch", e);

        // 0x3C with stop bit 0, line held low: FSM must wait for idle
        drive(1'b0, OS);
        for (int i = 0; i < 8; i++) drive(d_bit(8'h3C, i), OS);
        if (PAR_EN) drive(^8'h3C, OS);
        drive(1'b0, 3 * OS);
        check("wait_idle busy", 32'(busy), 32'h1);
        e = '{8'h3C, 1'b1, 1'b0, 1'b0};
        expect_word("stop error", e);
        drive(1'b1, OS);
        check("wait_idle released", 32'(busy), 32'h0);

        // Line low for 12 bit times: exactly one break word
        drive(1'b0, 12 * OS);
        drive(1'b1, 2 * OS);
        check("break word count", 32'(got_q.size()), 32'h1);
        e = '{8'h00, 1'b1, 1'b0, 1'b1};
        expect_word("break", e);
        send_frame(8'h5A, ^8'h5A, 2'b11);
        drive(1'b1, OS);
        e = '{8'h5A, 1'b0, 1'b0, 1'b0};
        expect_word("after break", e);

        // Overrun: consumer stalled across two words
        base = ovr_cnt;
        ready = 1'b0;
        send_frame(8'h11, ^8'h11, 2'b11);
        drive(1'b1, OS);
        send_frame(8'h22, ^8'h22, 2'b11);
        drive(1'b1, OS);
        check("overrun valid held", 32'(valid), 32'h1);
        check("overrun data kept", 32'(data), 32'h11);
        check("overrun pulses", 32'(ovr_cnt - base), 32'h1);
        $display("overrun: data=%02h pulses=%0d", data, ovr_cnt - base);
        ready = 1'b1;
        e = '{8'h11, 1'b0, 1'b0, 1'b0};
        expect_word("overrun drain", e);
        @(negedge clk);
        check("overrun valid cleared", 32'(valid), 32'h0);

        // Odd parity with a wrong parity bit
        if (PAR_EN) begin
            parity_odd = 1'b1;
            send_frame(8'h07, 1'b1, 2'b11);
            drive(1'b1, OS);
            e = '{8'h07, 1'b0, 1'b1, 1'b0};
            expect_word("odd parity", e);
            parity_odd = 1'b0;
        end

        // Reset mid-frame aborts with no word and no flags
        base = got_q.size();
        drive(1'b0, OS);
        drive(1'b1, 2 * OS);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b1, 12 * OS);
        check("abort busy", 32'(busy), 32'h0);
        check("abort valid", 32'(valid), 32'h0);
        check("abort frame_err", 32'(fe), 32'h0);
        check("abort no word", 32'(got_q.size()), 32'(base));

        // Randomized frames against the reference model
        for (int n = 0; n < 40; n++) begin
            d     = 8'($urandom);
            odd   = 1'($urandom);
            flip  = ($urandom_range(0, 3) == 0);
            stops = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
            parity_odd = odd;
            par   = (^d) ^ odd ^ flip;
            e     = model(d, par, stops, odd);
            send_frame(d, par, stops);
            drive(1'b1, $urandom_range(OS / 2, 2 * OS));
            expect_word($sformatf("rand%0d", n), e);
        end

        check("no stray words", 32'(got_q.size()), 32'h0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    function automatic logic d_bit(logic [7:0] v, int i);
        return v[i];
    endfunction

    // Watchdog so the run always ends
    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end
endmodule
